// File: rtl/seg_display_scheduler_if.sv
// Request/acknowledge bundle between two application-side requesters and the
// seg_display_scheduler; the application is master, the scheduler is slave.
interface seg_display_scheduler_if;
  logic       a_req;
  logic [7:0] a_val;
  logic       a_ack;
  logic       b_req;
  logic [7:0] b_val;
  logic       b_ack;
  logic       busy;

  modport master (
    output a_req, a_val, b_req, b_val,
    input  a_ack, b_ack, busy
  );

  modport slave (
    input  a_req, a_val, b_req, b_val,
    output a_ack, b_ack, busy
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin arbiter plus one-bit-per-clock binary-to-BCD converter feeding a
// multiplexed 8-digit 7-segment scanner (A on digits 6..4, B on digits 2..0).
module seg_display_scheduler #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                    CLK50MHZ,
  input  logic                    RSTn,
  seg_display_scheduler_if.slave  bus,
  output logic [6:0]              SEG,
  output logic [7:0]              AN
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [19:0]   sr_q, sr_d;
  logic          chan_b_q, chan_b_d;
  logic          last_b_q, last_b_d;

  logic          grant_a, grant_b;
  logic          do_load, do_shift, do_commit;

  logic [11:0]   a_dig_q, b_dig_q;
  logic          a_vld_q, b_vld_q;

  logic [CW-1:0] cnt_q;
  logic [2:0]    dig_idx_q;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;

  logic [11:0]   sel_dig;
  logic          sel_vld;
  logic [3:0]    digit_bcd;
  logic          digit_blank;

  // Both high: grant whichever channel was not served last.
  assign grant_a = bus.a_req && (!bus.b_req ||  last_b_q);
  assign grant_b = bus.b_req && (!bus.a_req || !last_b_q);

  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK50MHZ or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_a || grant_b)   state_d = ST_CONV;
      ST_CONV:   if (bit_cnt_q == 3'd7)    state_d = ST_COMMIT;
      ST_COMMIT:                           state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // The acks are decoded from IDLE so they can never appear in CONV/COMMIT.
  always_comb begin
    bus.a_ack = 1'b0;
    bus.b_ack = 1'b0;
    bus.busy  = 1'b0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.a_ack = grant_a;
        bus.b_ack = grant_b;
        do_load   = grant_a || grant_b;
      end
      ST_CONV: begin
        bus.busy = 1'b1;
        do_shift = 1'b1;
      end
      ST_COMMIT: begin
        bus.busy  = 1'b1;
        do_commit = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    chan_b_d  = chan_b_q;
    last_b_d  = last_b_q;
    if (do_load) begin
      sr_d      = {12'd0, grant_a ? bus.a_val : bus.b_val};
      bit_cnt_d = 3'd0;
      chan_b_d  = !grant_a;
      last_b_d  = !grant_a;
    end else if (do_shift) begin
      sr_d      = dabble_step(sr_q);
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RSTn) begin
    if (!RSTn) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      chan_b_q  <= 1'b0;
      last_b_q  <= 1'b1;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      chan_b_q  <= chan_b_d;
      last_b_q  <= last_b_d;
    end
  end

  // NOTE: the digit storage carries no reset; the valid flags are reset and
  // blank the display until a commit has written real data.
  always_ff @(posedge CLK50MHZ) begin
    if (do_commit &&  chan_b_q) b_dig_q <= sr_q[19:8];
    if (do_commit && !chan_b_q) a_dig_q <= sr_q[19:8];
  end

  always_ff @(posedge CLK50MHZ or negedge RSTn) begin
    if (!RSTn) begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
    end else if (do_commit) begin
      if (chan_b_q) b_vld_q <= 1'b1;
      else          a_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q     <= '0;
      dig_idx_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q     <= '0;
      dig_idx_q <= dig_idx_q + 3'd1;
    end else begin
      cnt_q     <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    sel_dig     = dig_idx_q[2] ? a_dig_q : b_dig_q;
    sel_vld     = dig_idx_q[2] ? a_vld_q : b_vld_q;
    digit_bcd   = 4'd0;
    digit_blank = 1'b1;
    case (dig_idx_q[1:0])
      2'd0: begin
        digit_bcd   = sel_dig[3:0];
        digit_blank = !sel_vld;
      end
      2'd1: begin
        digit_bcd   = sel_dig[7:4];
        digit_blank = !sel_vld ||
                      (BLANK_LZ && sel_dig[11:8] == 4'd0 && sel_dig[7:4] == 4'd0);
      end
      2'd2: begin
        digit_bcd   = sel_dig[11:8];
        digit_blank = !sel_vld || (BLANK_LZ && sel_dig[11:8] == 4'd0);
      end
      default: digit_blank = 1'b1;
    endcase
    seg_d = digit_blank ? 7'h7F : seg_lut(digit_bcd);
    an_d  = ~(8'd1 << dig_idx_q);
  end

  // Anode and cathodes move on the same edge, so a slot never shows the
  // neighbour's pattern.
  always_ff @(posedge CLK50MHZ or negedge RSTn) begin
    if (!RSTn) begin
      seg_q <= 7'h7F;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized self-checking bench for seg_display_scheduler; two instances
// (leading-zero blanking on and off) share one stimulus stream.
module tb_seg_display_scheduler;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg1, seg0;
  logic [7:0] an1, an0;

  int n_tests = 0;
  int n_fail  = 0;

  int a_m = 0, b_m = 0;
  bit a_ok_m = 0, b_ok_m = 0;
  bit last_b_m = 1;

  seg_display_scheduler_if if1();
  seg_display_scheduler_if if0();

  seg_display_scheduler #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_lz1 (
    .CLK50MHZ(clk), .RSTn(rst_n), .bus(if1), .SEG(seg1), .AN(an1)
  );

  seg_display_scheduler #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_lz0 (
    .CLK50MHZ(clk), .RSTn(rst_n), .bus(if0), .SEG(seg0), .AN(an0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0001100;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected cathodes for a digit position, derived from the decimal value.
  function automatic logic [6:0] model_seg(input int idx, input bit lz);
    int v; bit ok; int place; int div;
    if (idx == 3 || idx == 7) return 7'h7F;
    v     = (idx >= 4) ? a_m : b_m;
    ok    = (idx >= 4) ? a_ok_m : b_ok_m;
    place = idx % 4;
    if (!ok) return 7'h7F;
    if (lz && place == 2 && v < 100) return 7'h7F;
    if (lz && place == 1 && v < 10)  return 7'h7F;
    div = (place == 0) ? 1 : (place == 1) ? 10 : 100;
    return seg_of((v / div) % 10);
  endfunction

  function automatic int an_index(input logic [7:0] an);
    int idx; int zeros;
    idx = -1; zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (an[i] === 1'b0) begin idx = i; zeros++; end
    end
    return (zeros == 1) ? idx : -1;
  endfunction

  task automatic drive_a(input bit r, input int v);
    if0.a_req = r; if1.a_req = r;
    if0.a_val = 8'(v); if1.a_val = 8'(v);
  endtask

  task automatic drive_b(input bit r, input int v);
    if0.b_req = r; if1.b_req = r;
    if0.b_val = 8'(v); if1.b_val = 8'(v);
  endtask

  task automatic model_reset();
    a_ok_m = 0; b_ok_m = 0; last_b_m = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_a(0, 0); drive_b(0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_display(input string tag);
    int idx; logic [6:0] exp_seg;
    for (int c = 0; c < 9 * SCAN_DIV; c++) begin
      @(negedge clk);
      idx = an_index(an1);
      n_tests++;
      if (idx < 0) begin
        n_fail++;
        $display("FAIL %s an_lz1: got %h, required one-cold", tag, an1);
      end else begin
        exp_seg = model_seg(idx, 1'b1);
        n_tests++;
        if (seg1 !== exp_seg) begin
          n_fail++;
          $display("FAIL %s seg_lz1 digit %0d: got %b, required %b", tag, idx, seg1, exp_seg);
        end
      end
      idx = an_index(an0);
      n_tests++;
      if (idx < 0) begin
        n_fail++;
        $display("FAIL %s an_lz0: got %h, required one-cold", tag, an0);
      end else begin
        exp_seg = model_seg(idx, 1'b0);
        n_tests++;
        if (seg0 !== exp_seg) begin
          n_fail++;
          $display("FAIL %s seg_lz0 digit %0d: got %b, required %b", tag, idx, seg0, exp_seg);
        end
      end
    end
  endtask

  // Posts the requested channels, drops each request once acked, and checks
  // ack ordering/spacing, ack width and busy duration for both instances.
  task automatic run_reqs(input bit do_a, input int va, input bit do_b, input int vb,
                          input string tag);
    int a_cyc[2]; int b_cyc[2]; int a_cnt[2]; int b_cnt[2];
    int busy_cnt[2]; int ack_busy[2];
    bit a_first; int exp_a; int exp_b; bit drop_a; bit drop_b;
    a_first = do_a && (!do_b || last_b_m);
    exp_a   = !do_a ? -1 : (a_first ? 0 : 10);
    exp_b   = !do_b ? -1 : (a_first ? 10 : 0);
    for (int d = 0; d < 2; d++) begin
      a_cyc[d] = -1; b_cyc[d] = -1; a_cnt[d] = 0; b_cnt[d] = 0;
      busy_cnt[d] = 0; ack_busy[d] = 0;
    end
    @(posedge clk); #1;
    drive_a(do_a, va);
    drive_b(do_b, vb);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (if0.a_ack) begin a_cnt[0]++; a_cyc[0] = cyc; end
      if (if0.b_ack) begin b_cnt[0]++; b_cyc[0] = cyc; end
      if (if1.a_ack) begin a_cnt[1]++; a_cyc[1] = cyc; end
      if (if1.b_ack) begin b_cnt[1]++; b_cyc[1] = cyc; end
      if (if0.busy) busy_cnt[0]++;
      if (if1.busy) busy_cnt[1]++;
      if (if0.busy && (if0.a_ack || if0.b_ack)) ack_busy[0]++;
      if (if1.busy && (if1.a_ack || if1.b_ack)) ack_busy[1]++;
      drop_a = if1.a_ack;
      drop_b = if1.b_ack;
      @(posedge clk); #1;
      if (drop_a) drive_a(0, va);
      if (drop_b) drive_b(0, vb);
    end
    drive_a(0, va);
    drive_b(0, vb);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (a_cnt[d] != (do_a ? 1 : 0)) begin
        n_fail++;
        $display("FAIL %s a_ack_count[%0d]: got %0d, required %0d", tag, d, a_cnt[d], do_a ? 1 : 0);
      end
      n_tests++;
      if (b_cnt[d] != (do_b ? 1 : 0)) begin
        n_fail++;
        $display("FAIL %s b_ack_count[%0d]: got %0d, required %0d", tag, d, b_cnt[d], do_b ? 1 : 0);
      end
      n_tests++;
      if (a_cyc[d] != exp_a) begin
        n_fail++;
        $display("FAIL %s a_ack_cycle[%0d]: got %0d, required %0d", tag, d, a_cyc[d], exp_a);
      end
      n_tests++;
      if (b_cyc[d] != exp_b) begin
        n_fail++;
        $display("FAIL %s b_ack_cycle[%0d]: got %0d, required %0d", tag, d, b_cyc[d], exp_b);
      end
      n_tests++;
      if (busy_cnt[d] != 9 * (int'(do_a) + int'(do_b))) begin
        n_fail++;
        $display("FAIL %s busy_cycles[%0d]: got %0d, required %0d", tag, d, busy_cnt[d],
                 9 * (int'(do_a) + int'(do_b)));
      end
      n_tests++;
      if (ack_busy[d] != 0) begin
        n_fail++;
        $display("FAIL %s ack_while_busy[%0d]: got %0d, required 0", tag, d, ack_busy[d]);
      end
    end
    if (do_a) begin a_m = va; a_ok_m = 1; end
    if (do_b) begin b_m = vb; b_ok_m = 1; end
    if (do_a || do_b) last_b_m = do_b && (!do_a || a_first);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(0, 0); drive_b(0, 0);
    #12;
    n_tests++;
    if (an1 !== 8'hFF || an0 !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_an: got %h/%h, required ff", an1, an0);
    end
    n_tests++;
    if (seg1 !== 7'h7F || seg0 !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_seg: got %h/%h, required 7f", seg1, seg0);
    end
    n_tests++;
    if (if1.a_ack !== 1'b0 || if1.b_ack !== 1'b0 || if1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ack %b%b busy %b, required 0", if1.a_ack, if1.b_ack, if1.busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (an1 !== 8'hFE || seg1 !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_first_slot: got an %h seg %h, required fe 7f", an1, seg1);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (an1 !== 8'hFD || seg1 !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_second_slot: got an %h seg %h, required fd 7f", an1, seg1);
    end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] prev; logic [7:0] exp_an; int len; bit seen;
    @(negedge clk);
    prev = an1;
    seen = 0;
    for (int c = 0; c < 3 * SCAN_DIV && !seen; c++) begin
      @(negedge clk);
      if (an1 !== prev) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL scan_sync: got no anode change, required one within %0d clocks", 3 * SCAN_DIV);
    end
    prev = an1;
    for (int s = 0; s < 16; s++) begin
      exp_an = {prev[6:0], prev[7]};
      len = 0;
      seen = 0;
      for (int c = 0; c < 3 * SCAN_DIV && !seen; c++) begin
        @(negedge clk);
        len++;
        if (an1 !== prev) seen = 1;
      end
      n_tests++;
      if (len != SCAN_DIV || an1 !== exp_an) begin
        n_fail++;
        $display("FAIL scan_slot %0d: got an %h after %0d clocks, required %h after %0d",
                 s, an1, len, exp_an, SCAN_DIV);
      end
      prev = an1;
    end
  endtask

  task automatic test_single_a();
    run_reqs(1, 237, 0, 0, "single_a237");
    check_display("single_a237");
  endtask

  task automatic test_tie();
    do_reset();
    run_reqs(1, 5, 1, 99, "tie_after_reset");
    check_display("tie_after_reset");
    run_reqs(1, 42, 1, 7, "tie_rotate");
    check_display("tie_rotate");
  endtask

  task automatic test_zero();
    run_reqs(1, 0, 0, 0, "zero_a");
    check_display("zero_a");
  endtask

  task automatic test_boundaries();
    int vals[6];
    vals = '{0, 9, 10, 99, 100, 255};
    for (int i = 0; i < 6; i++) begin
      run_reqs(i[0], vals[i], !i[0], vals[5 - i], "boundary");
      check_display("boundary");
    end
  endtask

  task automatic test_back_to_back();
    bit da; bit db;
    for (int i = 0; i < 10; i++) begin
      da = 1'($urandom_range(0, 1));
      db = da ? 1'($urandom_range(0, 1)) : 1'b1;
      run_reqs(da, int'($urandom_range(0, 255)), db, int'($urandom_range(0, 255)), "random");
      check_display("random");
    end
  endtask

  task automatic test_reset_mid_conv();
    run_reqs(1, 255, 0, 0, "max_a");
    check_display("max_a");
    @(posedge clk); #1;
    drive_a(1, 17);
    @(negedge clk);
    n_tests++;
    if (if1.a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL midconv_grant: got a_ack %b, required 1", if1.a_ack);
    end
    @(posedge clk); #1;
    drive_a(0, 17);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (an1 !== 8'hFF || seg1 !== 7'h7F || if1.busy !== 1'b0 || if0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midconv_reset: got an %h seg %h busy %b, required ff 7f 0", an1, seg1, if1.busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_tests++;
      if (if1.a_ack || if1.b_ack || if1.busy || if0.a_ack || if0.busy) begin
        n_fail++;
        $display("FAIL midconv_quiet cycle %0d: got ack %b busy %b, required 0", c, if1.a_ack, if1.busy);
      end
    end
    check_display("midconv_blank");
  endtask

  initial begin
    test_reset();
    test_scan_wrap();
    test_single_a();
    test_tie();
    test_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_conv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
